// File: rtl/c_align_buffer.sv
// c_align_buffer: fetch-side instruction realignment buffer for RV32IC.
// Fetch words of FETCH_HW halfwords go into a circular halfword queue; the
// head is decoded as a 16-bit compressed or 32-bit instruction and issued
// with its PC under valid/ready handshakes. A redirect (flush_i) empties the
// queue and restarts at flush_pc_i, skipping the halfwords of the first fetch
// word that lie below the target.
// Optional feature macro: C_ALIGN_PERF_EN adds issued-instruction counters.
module c_align_buffer #(
  parameter int          FETCH_HW = 2,
  parameter int          DEPTH_HW = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    reset_i,
  input  logic                    flush_i,
  input  logic [31:0]             flush_pc_i,
  input  logic                    fetch_valid_i,
  output logic                    fetch_ready_o,
  input  logic [16*FETCH_HW-1:0]  fetch_data_i,
  output logic                    instr_valid_o,
  input  logic                    instr_ready_i,
  output logic [31:0]             instr_o,
  output logic [31:0]             instr_pc_o,
  output logic                    instr_compressed_o
`ifdef C_ALIGN_PERF_EN
  ,
  output logic [31:0]             perf_c_cnt_o,
  output logic [31:0]             perf_i_cnt_o
`endif
);

  localparam int PTR_W  = $clog2(DEPTH_HW);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SKIP_W = (FETCH_HW > 1) ? $clog2(FETCH_HW) : 1;

  localparam logic [CNT_W-1:0] FETCH_CNT = CNT_W'(FETCH_HW);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH_HW);

  logic [15:0]       mem_q [DEPTH_HW];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       pc_q, pc_d;
  logic [SKIP_W-1:0] skip_q, skip_d;

  logic [PTR_W-1:0]  rd_ptr_p1;
  logic [15:0]       hw0, hw1;
  logic              is_c;
  logic              push, pop;
  logic [CNT_W-1:0]  push_n, pop_n;
  logic [FETCH_HW-1:0] wr_en;
  logic [PTR_W-1:0]  wr_idx [FETCH_HW];

  // Head decode: the two oldest halfwords, with wrap, form the candidate instruction.
  always_comb begin
    rd_ptr_p1          = rd_ptr_q + 1'b1;
    hw0                = mem_q[rd_ptr_q];
    hw1                = mem_q[rd_ptr_p1];
    is_c               = (hw0[1:0] != 2'b11);
    instr_compressed_o = is_c;
    instr_o            = is_c ? {16'h0000, hw0} : {hw1, hw0};
    instr_pc_o         = pc_q;
    instr_valid_o      = !flush_i && (is_c ? (count_q >= CNT_W'(1)) : (count_q >= CNT_W'(2)));
    fetch_ready_o      = (DEPTH_CNT - count_q) >= FETCH_CNT;
  end

  // Handshakes and the number of halfwords entering and leaving this cycle.
  always_comb begin
    push   = fetch_valid_i && fetch_ready_o && !flush_i;
    pop    = instr_valid_o && instr_ready_i;
    push_n = push ? (FETCH_CNT - CNT_W'(skip_q)) : '0;
    pop_n  = pop ? (is_c ? CNT_W'(1) : CNT_W'(2)) : '0;
  end

  // Per-halfword write enables: halfwords below skip_q are dropped and the rest
  // are packed contiguously from wr_ptr upward.
  always_comb begin
    for (int i = 0; i < FETCH_HW; i++) begin
      wr_en[i]  = push && (i >= int'(skip_q));
      wr_idx[i] = wr_ptr_q + PTR_W'(i) - PTR_W'(skip_q);
    end
  end

  // Next-state for pointers, occupancy, PC and skip; flush overrides push and pop.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    pc_d     = pc_q;
    skip_d   = skip_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      pc_d     = flush_pc_i & 32'hFFFF_FFFE;
      skip_d   = flush_pc_i[SKIP_W:1];
    end else begin
      count_d  = count_q + push_n - pop_n;
      wr_ptr_d = wr_ptr_q + push_n[PTR_W-1:0];
      rd_ptr_d = rd_ptr_q + pop_n[PTR_W-1:0];
      if (pop) begin
        pc_d = pc_q + (is_c ? 32'd2 : 32'd4);
      end
      if (push) begin
        skip_d = '0;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pc_q     <= RESET_PC;
      skip_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      pc_q     <= pc_d;
      skip_q   <= skip_d;
    end
  end

  // Halfword storage.
  always_ff @(posedge clk or posedge reset_i) begin
    // NOTE: the storage is reset so the head decodes to a defined value (instr_o 0, compressed) out of reset.
    if (reset_i) begin
      for (int i = 0; i < DEPTH_HW; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < FETCH_HW; i++) begin
        if (wr_en[i]) begin
          mem_q[wr_idx[i]] <= fetch_data_i[16*i +: 16];
        end
      end
    end
  end

`ifdef C_ALIGN_PERF_EN
  logic [31:0] perf_c_q, perf_i_q;

  // Issued-instruction counters by type; cleared by reset only, never by flush.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      perf_c_q <= '0;
      perf_i_q <= '0;
    end else if (pop) begin
      if (is_c) perf_c_q <= perf_c_q + 32'd1;
      else      perf_i_q <= perf_i_q + 32'd1;
    end
  end

  assign perf_c_cnt_o = perf_c_q;
  assign perf_i_cnt_o = perf_i_q;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_c_align_buffer.sv
// Directed testbench for c_align_buffer with FETCH_HW=2, DEPTH_HW=8, RESET_PC=0.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_c_align_buffer;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = '0;
  logic        fetch_valid_i = 1'b0;
  logic        fetch_ready_o;
  logic [31:0] fetch_data_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_compressed_o;
`ifdef C_ALIGN_PERF_EN
  logic [31:0] perf_c_cnt_o;
  logic [31:0] perf_i_cnt_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  c_align_buffer #(.FETCH_HW(2), .DEPTH_HW(8), .RESET_PC(32'h0000_0000)) dut (
    .clk                (clk),
    .reset_i            (reset_i),
    .flush_i            (flush_i),
    .flush_pc_i         (flush_pc_i),
    .fetch_valid_i      (fetch_valid_i),
    .fetch_ready_o      (fetch_ready_o),
    .fetch_data_i       (fetch_data_i),
    .instr_valid_o      (instr_valid_o),
    .instr_ready_i      (instr_ready_i),
    .instr_o            (instr_o),
    .instr_pc_o         (instr_pc_o),
    .instr_compressed_o (instr_compressed_o)
`ifdef C_ALIGN_PERF_EN
    ,
    .perf_c_cnt_o       (perf_c_cnt_o),
    .perf_i_cnt_o       (perf_i_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    reset_i = 1'b1; flush_i = 1'b0; fetch_valid_i = 1'b0; instr_ready_i = 1'b0;
    flush_pc_i = '0; fetch_data_i = '0;
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  // Called at a falling edge; presents one word across the next rising edge.
  task automatic push_word(input logic [31:0] w);
    fetch_valid_i = 1'b1; fetch_data_i = w;
    @(negedge clk);
    fetch_valid_i = 1'b0;
  endtask

  // Called at a falling edge; accepts the head across the next rising edge.
  task automatic pop_one();
    instr_ready_i = 1'b1;
    @(negedge clk);
    instr_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (instr_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", instr_valid_o); end
    n_cmp++; if (fetch_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", fetch_ready_o); end
    n_cmp++; if (instr_o !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %h want 00000000", instr_o); end
    n_cmp++; if (instr_pc_o !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 00000000", instr_pc_o); end
    n_cmp++; if (instr_compressed_o !== 1'b1) begin n_bad++; $display("FAIL reset_comp: got %b want 1", instr_compressed_o); end
    reset_i = 1'b0;
    @(negedge clk);
    push_word(32'h0000_0013);
    n_cmp++; if (instr_valid_o !== 1'b1) begin n_bad++; $display("FAIL pre_async_valid: got %b want 1", instr_valid_o); end
    #2 reset_i = 1'b1;
    #1;
    n_cmp++; if (instr_valid_o !== 1'b0) begin n_bad++; $display("FAIL async_reset_valid: got %b want 0", instr_valid_o); end
    n_cmp++; if (instr_o !== 32'h0) begin n_bad++; $display("FAIL async_reset_instr: got %h want 00000000", instr_o); end
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  task automatic test_single_32();
    apply_reset();
    push_word(32'h0000_0013);
    n_cmp++; if (instr_valid_o !== 1'b1) begin n_bad++; $display("FAIL s32_valid: got %b want 1", instr_valid_o); end
    n_cmp++; if (instr_o !== 32'h0000_0013) begin n_bad++; $display("FAIL s32_instr: got %h want 00000013", instr_o); end
    n_cmp++; if (instr_pc_o !== 32'h0) begin n_bad++; $display("FAIL s32_pc: got %h want 00000000", instr_pc_o); end
    n_cmp++; if (instr_compressed_o !== 1'b0) begin n_bad++; $display("FAIL s32_comp: got %b want 0", instr_compressed_o); end
    pop_one();
    n_cmp++; if (instr_valid_o !== 1'b0) begin n_bad++; $display("FAIL s32_empty: got %b want 0", instr_valid_o); end
    n_cmp++; if (instr_pc_o !== 32'h4) begin n_bad++; $display("FAIL s32_next_pc: got %h want 00000004", instr_pc_o); end
  endtask

  task automatic test_two_compressed();
    logic [31:0] exp_i [2];
    logic [31:0] exp_pc [2];
    exp_i[0] = 32'h0000_4485; exp_pc[0] = 32'h0;
    exp_i[1] = 32'h0000_4501; exp_pc[1] = 32'h2;
    apply_reset();
    push_word(32'h4501_4485);
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (instr_valid_o !== 1'b1) begin n_bad++; $display("FAIL c2_valid[%0d]: got %b want 1", k, instr_valid_o); end
      n_cmp++; if (instr_o !== exp_i[k]) begin n_bad++; $display("FAIL c2_instr[%0d]: got %h want %h", k, instr_o, exp_i[k]); end
      n_cmp++; if (instr_pc_o !== exp_pc[k]) begin n_bad++; $display("FAIL c2_pc[%0d]: got %h want %h", k, instr_pc_o, exp_pc[k]); end
      n_cmp++; if (instr_compressed_o !== 1'b1) begin n_bad++; $display("FAIL c2_comp[%0d]: got %b want 1", k, instr_compressed_o); end
      pop_one();
    end
    n_cmp++; if (instr_valid_o !== 1'b0) begin n_bad++; $display("FAIL c2_empty: got %b want 0", instr_valid_o); end
  endtask

  task automatic test_straddle();
    apply_reset();
    push_word(32'h0513_4485);
    n_cmp++; if (instr_o !== 32'h0000_4485) begin n_bad++; $display("FAIL st_c_instr: got %h want 00004485", instr_o); end
    n_cmp++; if (instr_valid_o !== 1'b1) begin n_bad++; $display("FAIL st_c_valid: got %b want 1", instr_valid_o); end
    pop_one();
    n_cmp++; if (instr_valid_o !== 1'b0) begin n_bad++; $display("FAIL st_hold_valid: got %b want 0", instr_valid_o); end
    n_cmp++; if (instr_compressed_o !== 1'b0) begin n_bad++; $display("FAIL st_hold_comp: got %b want 0", instr_compressed_o); end
    // Consumer is ready while the upper half is missing: nothing may issue.
    pop_one();
    n_cmp++; if (instr_pc_o !== 32'h2) begin n_bad++; $display("FAIL st_hold_pc: got %h want 00000002", instr_pc_o); end
    push_word(32'h0000_0000);
    n_cmp++; if (instr_valid_o !== 1'b1) begin n_bad++; $display("FAIL st_i_valid: got %b want 1", instr_valid_o); end
    n_cmp++; if (instr_o !== 32'h0000_0513) begin n_bad++; $display("FAIL st_i_instr: got %h want 00000513", instr_o); end
    n_cmp++; if (instr_pc_o !== 32'h2) begin n_bad++; $display("FAIL st_i_pc: got %h want 00000002", instr_pc_o); end
    pop_one();
    n_cmp++; if (instr_valid_o !== 1'b1) begin n_bad++; $display("FAIL st_tail_valid: got %b want 1", instr_valid_o); end
    n_cmp++; if (instr_pc_o !== 32'h6) begin n_bad++; $display("FAIL st_tail_pc: got %h want 00000006", instr_pc_o); end
    n_cmp++; if (instr_compressed_o !== 1'b1) begin n_bad++; $display("FAIL st_tail_comp: got %b want 1", instr_compressed_o); end
    pop_one();
    n_cmp++; if (instr_valid_o !== 1'b0) begin n_bad++; $display("FAIL st_empty: got %b want 0", instr_valid_o); end
  endtask

  task automatic test_full();
    logic [15:0] hw;
    logic [15:0] hw_hi;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      hw    = 16'h1000 + 16'(8 * i);
      hw_hi = 16'h1000 + 16'(8 * i + 4);
      n_cmp++; if (fetch_ready_o !== 1'b1) begin n_bad++; $display("FAIL full_ready[%0d]: got %b want 1", i, fetch_ready_o); end
      push_word({hw_hi, hw});
    end
    n_cmp++; if (fetch_ready_o !== 1'b0) begin n_bad++; $display("FAIL full_not_ready: got %b want 0", fetch_ready_o); end
    // Offered while full: must be ignored.
    push_word(32'hFFFF_FFFF);
    for (int k = 0; k < 8; k++) begin
      hw = 16'h1000 + 16'(4 * k);
      n_cmp++; if (instr_valid_o !== 1'b1) begin n_bad++; $display("FAIL drain_valid[%0d]: got %b want 1", k, instr_valid_o); end
      n_cmp++; if (instr_o !== {16'h0000, hw}) begin n_bad++; $display("FAIL drain_instr[%0d]: got %h want %h", k, instr_o, {16'h0000, hw}); end
      n_cmp++; if (instr_pc_o !== 32'(2 * k)) begin n_bad++; $display("FAIL drain_pc[%0d]: got %h want %h", k, instr_pc_o, 32'(2 * k)); end
      pop_one();
    end
    n_cmp++; if (instr_valid_o !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got %b want 0", instr_valid_o); end
    n_cmp++; if (fetch_ready_o !== 1'b1) begin n_bad++; $display("FAIL drain_ready: got %b want 1", fetch_ready_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_i [4];
    exp_i[0] = 32'h0000_4485; exp_i[1] = 32'h0000_4501;
    exp_i[2] = 32'h0000_0005; exp_i[3] = 32'h0000_0001;
    apply_reset();
    push_word(32'h4501_4485);
    fetch_valid_i = 1'b1; fetch_data_i = 32'h0001_0005; instr_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (instr_valid_o !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", k, instr_valid_o); end
      n_cmp++; if (instr_o !== exp_i[k]) begin n_bad++; $display("FAIL b2b_instr[%0d]: got %h want %h", k, instr_o, exp_i[k]); end
      n_cmp++; if (instr_pc_o !== 32'(2 * k)) begin n_bad++; $display("FAIL b2b_pc[%0d]: got %h want %h", k, instr_pc_o, 32'(2 * k)); end
      @(negedge clk);
      fetch_valid_i = 1'b0;
    end
    instr_ready_i = 1'b0;
    n_cmp++; if (instr_valid_o !== 1'b0) begin n_bad++; $display("FAIL b2b_empty: got %b want 0", instr_valid_o); end
    n_cmp++; if (instr_pc_o !== 32'h8) begin n_bad++; $display("FAIL b2b_pc_end: got %h want 00000008", instr_pc_o); end
  endtask

  task automatic test_flush();
    apply_reset();
    push_word(32'h7777_6665);
    n_cmp++; if (instr_valid_o !== 1'b1) begin n_bad++; $display("FAIL fl_pre_valid: got %b want 1", instr_valid_o); end
    flush_i = 1'b1; flush_pc_i = 32'h0000_0103;
    fetch_valid_i = 1'b1; fetch_data_i = 32'hAAAA_AAA9; instr_ready_i = 1'b1;
    #1;
    n_cmp++; if (instr_valid_o !== 1'b0) begin n_bad++; $display("FAIL fl_during_valid: got %b want 0", instr_valid_o); end
    @(negedge clk);
    flush_i = 1'b0; fetch_valid_i = 1'b0; instr_ready_i = 1'b0;
    n_cmp++; if (fetch_ready_o !== 1'b1) begin n_bad++; $display("FAIL fl_ready: got %b want 1", fetch_ready_o); end
    n_cmp++; if (instr_valid_o !== 1'b0) begin n_bad++; $display("FAIL fl_after_valid: got %b want 0", instr_valid_o); end
    n_cmp++; if (instr_pc_o !== 32'h0000_0102) begin n_bad++; $display("FAIL fl_pc: got %h want 00000102", instr_pc_o); end
    push_word(32'h4501_4485);
    n_cmp++; if (instr_valid_o !== 1'b1) begin n_bad++; $display("FAIL fl_tgt_valid: got %b want 1", instr_valid_o); end
    n_cmp++; if (instr_o !== 32'h0000_4501) begin n_bad++; $display("FAIL fl_tgt_instr: got %h want 00004501", instr_o); end
    n_cmp++; if (instr_pc_o !== 32'h0000_0102) begin n_bad++; $display("FAIL fl_tgt_pc: got %h want 00000102", instr_pc_o); end
    pop_one();
    n_cmp++; if (instr_valid_o !== 1'b0) begin n_bad++; $display("FAIL fl_empty: got %b want 0", instr_valid_o); end
    n_cmp++; if (instr_pc_o !== 32'h0000_0104) begin n_bad++; $display("FAIL fl_next_pc: got %h want 00000104", instr_pc_o); end
  endtask

`ifdef C_ALIGN_PERF_EN
  task automatic test_perf();
    apply_reset();
    n_cmp++; if (perf_c_cnt_o !== 32'd0) begin n_bad++; $display("FAIL perf_c_reset: got %0d want 0", perf_c_cnt_o); end
    n_cmp++; if (perf_i_cnt_o !== 32'd0) begin n_bad++; $display("FAIL perf_i_reset: got %0d want 0", perf_i_cnt_o); end
    push_word(32'h4501_4485);
    push_word(32'h0000_0013);
    push_word(32'h0000_0013);
    push_word(32'h0001_4485);
    for (int k = 0; k < 5; k++) pop_one();
    n_cmp++; if (perf_c_cnt_o !== 32'd3) begin n_bad++; $display("FAIL perf_c: got %0d want 3", perf_c_cnt_o); end
    n_cmp++; if (perf_i_cnt_o !== 32'd2) begin n_bad++; $display("FAIL perf_i: got %0d want 2", perf_i_cnt_o); end
    flush_i = 1'b1; flush_pc_i = 32'h0000_0040; instr_ready_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0; instr_ready_i = 1'b0;
    n_cmp++; if (perf_c_cnt_o !== 32'd3) begin n_bad++; $display("FAIL perf_c_flush: got %0d want 3", perf_c_cnt_o); end
    n_cmp++; if (perf_i_cnt_o !== 32'd2) begin n_bad++; $display("FAIL perf_i_flush: got %0d want 2", perf_i_cnt_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_32();
    test_two_compressed();
    test_straddle();
    test_full();
    test_back_to_back();
    test_flush();
`ifdef C_ALIGN_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/c_align_buffer.md
# c_align_buffer

Parametrised fetch-side instruction realignment buffer for the RV32IC front end. It accepts naturally aligned fetch words of FETCH_HW halfwords and stores them in a circular halfword queue. It emits one aligned instruction per cycle, either a 16-bit compressed or a 32-bit instruction, with its PC, and handles instructions that straddle fetch words. It sits between the instruction memory port and the compressed decoder, and replaces the single-word misalign/stall scheme with valid/ready backpressure and branch-target redirect.

## Interface
- FETCH_HW, 2, halfwords per fetch word; legal values 2 (32-bit fetch) or 4 (64-bit fetch)
- DEPTH_HW, 8, buffer capacity in halfwords; power of two, at least 2*FETCH_HW
- RESET_PC, 32'h0000_0000, PC of the first instruction after reset; aligned to 2*FETCH_HW bytes
- clk  input  1  clock; all state updates on the rising edge
- reset_i  input  1  asynchronous, active-high reset
- flush_i  input  1  redirect (branch taken or exception); takes priority over all other inputs
- flush_pc_i  input  32  redirect target; bit 0 is ignored
- fetch_valid_i  input  1  fetch word present
- fetch_ready_o  output  1  buffer can accept a full fetch word
- fetch_data_i  input  16*FETCH_HW  fetch word; halfword 0 is at the lowest address
- instr_valid_o  output  1  complete instruction at head
- instr_ready_i  input  1  consumer takes the instruction
- instr_o  output  32  instruction; compressed instructions are zero-extended to {16'h0, hw}
- instr_pc_o  output  32  PC of instr_o
- instr_compressed_o  output  1  head halfword bits[1:0] != 2'b11
- perf_c_cnt_o  output  32  compressed instructions issued (only with C_ALIGN_PERF_EN)
- perf_i_cnt_o  output  32  32-bit instructions issued (only with C_ALIGN_PERF_EN)

## Operation
- State: halfword storage [DEPTH_HW], rd_ptr and wr_ptr (log2 DEPTH_HW bits, wrap modulo DEPTH_HW), count (log2 DEPTH_HW + 1 bits), pc_q (32 bits), skip_q (log2 FETCH_HW bits).
- Reset values: storage, pointers and count are 0, pc_q = RESET_PC, skip_q = 0. Resulting outputs: instr_valid_o 0, fetch_ready_o 1, instr_o 32'h0, instr_pc_o RESET_PC, instr_compressed_o 1, perf counters 0.
- Push: the fetch handshake is fetch_valid_i && fetch_ready_o && !flush_i.
  - On a push, halfwords skip_q..FETCH_HW-1 are written at wr_ptr upward, and count and wr_ptr advance by FETCH_HW-skip_q.
  - skip_q clears after the push.
- fetch_ready_o = (DEPTH_HW - count) >= FETCH_HW. It is a function of registered state only; it does not depend on instr_ready_i.
- Head decode: hw0 = storage[rd_ptr], hw1 = storage[rd_ptr+1] with wrap. The instruction is compressed when hw0[1:0] != 2'b11.
- instr_valid_o = !flush_i && (compressed ? count >= 1 : count >= 2).
- instr_o = compressed ? {16'h0, hw0} : {hw1, hw0}. Encodings longer than 32 bits are not supported and are treated as 32-bit.
- Pop: on instr_valid_o && instr_ready_i, rd_ptr and count drop by 1 (compressed) or 2 (32-bit), and pc_q advances by 2 or 4.
- A push and a pop in the same cycle both apply: count_next = count + pushed - popped.
- Flush:
  - Pointers and count clear.
  - pc_q loads {flush_pc_i[31:1], 1'b0}.
  - skip_q loads flush_pc_i[log2(FETCH_HW):1].
  - Any push or pop in the flush cycle is discarded.
  - The fetch unit supplies the aligned word that contains flush_pc_i.
- A 32-bit instruction whose upper half has not arrived yet is held with instr_valid_o 0 until the next push.
- A reset asserted mid-operation returns every register to its reset value immediately, independent of clk.

## Timing
- A fetch word pushed at edge N produces its first instruction valid in the cycle after N. There is no combinational path from fetch inputs to instr outputs.
- Sustained throughput is one instruction per cycle when the buffer is not starved.
- After flush_i at edge N, fetch_ready_o is 1 in cycle N+1, and the earliest valid instruction is in cycle N+2.
- When the buffer is full (count == DEPTH_HW), fetch_ready_o is 0 and pops continue.
- When the buffer is empty, instr_valid_o is 0 and pushes continue.

## Configuration
- C_ALIGN_PERF_EN, when defined:
  - perf_c_cnt_o and perf_i_cnt_o exist. Each increments by 1 on every pop of its instruction type and wraps at 2^32.
  - Both counters clear on reset only; a flush does not clear them.
- When C_ALIGN_PERF_EN is undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset, then push 32'h0000_0013 (FETCH_HW=2) -> one cycle later instr_valid_o=1, instr_o=32'h0000_0013, instr_pc_o=RESET_PC, instr_compressed_o=0.
- Push 32'h4501_4485 (two compressed) -> two consecutive pops: 32'h0000_4485 at PC 0, then 32'h0000_4501 at PC 2.
- Push {16'h0513 (low half of a 32-bit), 16'h4485 (compressed)} = 32'h0513_4485, then 32'h0000_0000 -> compressed 32'h0000_4485 at PC 0. The straddling 32-bit instruction issues only after the second push, with instr_o={16'h0000,16'h0513} at PC 2.
- Hold instr_ready_i=0 and push continuously with DEPTH_HW=8 -> fetch_ready_o drops after 4 pushes. Release instr_ready_i -> all 8 halfwords drain in order, with no loss and no duplicate.
- flush_i with flush_pc_i=32'h0000_0102, then push word 32'h4501_4485 -> only 32'h0000_4501 is issued, at PC 32'h0000_0102. Data buffered before the flush never appears.
- With C_ALIGN_PERF_EN defined, issue 3 compressed and 2 32-bit instructions -> perf_c_cnt_o=3, perf_i_cnt_o=2. A flush leaves both values unchanged.
